// File: rtl/mealy_run_tracker.sv
// Multi-channel Mealy run-length tracker: per-channel run counters with combinational
// run/hit/run_end/last_len outputs and a registered saturating count of completed runs.
module mealy_run_tracker #(
   parameter int CH      = 4,
   parameter int MAX_RUN = 7,
   parameter int THRESH  = 3,
   parameter int WRAP    = 0,
   parameter int CNT_W   = 16,
   localparam int CW     = $clog2(MAX_RUN + 1)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                en,
   input  logic                clear,
   input  logic [CH-1:0]       in,
   output logic [CH*CW-1:0]    run,
   output logic [CH-1:0]       hit,
   output logic [CH-1:0]       run_end,
   output logic [CH*CW-1:0]    last_len,
   output logic [CNT_W-1:0]    runs_done
);

   localparam int EW = $clog2(CH + 1);
   localparam int SW = CNT_W + EW;
   localparam logic [CW-1:0] MAX_R = CW'(MAX_RUN);
   localparam logic [CW-1:0] THR   = CW'(THRESH);
   localparam logic [SW-1:0] CNT_MAX = SW'({CNT_W{1'b1}});

   logic [CW-1:0]    r_q [CH];
   logic [CW-1:0]    r_d [CH];
   logic [CNT_W-1:0] runs_done_q, runs_done_d;
   logic [EW-1:0]    ends_n;
   logic [SW-1:0]    sum;

   // Successor of a run length: clamp or wrap at MAX_RUN so r never overflows.
   function automatic logic [CW-1:0] next_len(input logic [CW-1:0] r);
      if (r == MAX_R) return (WRAP != 0) ? CW'(1) : MAX_R;
      return r + CW'(1);
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int c = 0; c < CH; c++) r_q[c] <= '0;
         runs_done_q <= '0;
      end else begin
         for (int c = 0; c < CH; c++) r_q[c] <= r_d[c];
         runs_done_q <= runs_done_d;
      end
   end

   always_comb begin
      for (int c = 0; c < CH; c++) r_d[c] = r_q[c];
      ends_n      = '0;
      sum         = '0;
      runs_done_d = runs_done_q;
      if (clear) begin
         for (int c = 0; c < CH; c++) r_d[c] = '0;
         runs_done_d = '0;
      end else if (en) begin
         for (int c = 0; c < CH; c++) begin
            r_d[c] = in[c] ? next_len(r_q[c]) : '0;
            ends_n = ends_n + EW'(run_end[c]);
         end
         sum = SW'(runs_done_q) + SW'(ends_n);
         runs_done_d = (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
      end
   end

   // Mealy outputs are gated off during reset and during a clear cycle.
   always_comb begin
      run      = '0;
      hit      = '0;
      run_end  = '0;
      last_len = '0;
      if (reset_n && !clear) begin
         for (int c = 0; c < CH; c++) begin
            if (!en) begin
               run[c*CW +: CW] = r_q[c];
            end else if (in[c]) begin
               run[c*CW +: CW] = next_len(r_q[c]);
               hit[c]          = (next_len(r_q[c]) == THR) && (r_q[c] != THR);
            end else begin
               run_end[c]           = (r_q[c] != '0);
               last_len[c*CW +: CW] = r_q[c];
            end
         end
      end
   end

   assign runs_done = runs_done_q;

endmodule

// File: tb/tb_mealy_run_tracker.sv
// Directed bench for mealy_run_tracker: three instances (saturating, wrapping, 2-bit counter)
// share one stimulus stream; every expectation below is hand-computed.
module tb_mealy_run_tracker;

   logic        clk = 1'b0;
   logic        reset_n, en, clear;
   logic [3:0]  in_v;
   int          total = 0;
   int          bad   = 0;

   logic [11:0] run_a, last_a, run_w, last_w, run_c, last_c;
   logic [3:0]  hit_a, end_a, hit_w, end_w, hit_c, end_c;
   logic [15:0] done_a, done_w;
   logic [1:0]  done_c;

   always #5 clk = ~clk;

   mealy_run_tracker #(.CH(4), .MAX_RUN(7), .THRESH(3), .WRAP(0), .CNT_W(16)) u_a (
      .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .in(in_v),
      .run(run_a), .hit(hit_a), .run_end(end_a), .last_len(last_a), .runs_done(done_a));

   mealy_run_tracker #(.CH(4), .MAX_RUN(7), .THRESH(3), .WRAP(1), .CNT_W(16)) u_w (
      .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .in(in_v),
      .run(run_w), .hit(hit_w), .run_end(end_w), .last_len(last_w), .runs_done(done_w));

   mealy_run_tracker #(.CH(4), .MAX_RUN(7), .THRESH(3), .WRAP(0), .CNT_W(2)) u_c (
      .clk(clk), .reset_n(reset_n), .en(en), .clear(clear), .in(in_v),
      .run(run_c), .hit(hit_c), .run_end(end_c), .last_len(last_c), .runs_done(done_c));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive just after the falling edge, then settle so Mealy outputs can be sampled.
   task automatic cyc(input logic e, input logic c, input logic [3:0] i);
      @(negedge clk);
      en    = e;
      clear = c;
      in_v  = i;
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      en      = 1'b1;
      clear   = 1'b0;
      in_v    = 4'hF;
      #3;
      chk("rst_run_a",  32'(run_a),  0);
      chk("rst_hit_a",  32'(hit_a),  0);
      chk("rst_end_a",  32'(end_a),  0);
      chk("rst_last_a", 32'(last_a), 0);
      chk("rst_done_a", 32'(done_a), 0);
      chk("rst_run_w",  32'(run_w),  0);
      chk("rst_done_c", 32'(done_c), 0);

      @(negedge clk);
      reset_n = 1'b1;
      in_v    = 4'h0;
      #1;
      chk("rel_run_a",  32'(run_a),  0);
      chk("rel_end_a",  32'(end_a),  0);
      chk("rel_done_a", 32'(done_a), 0);

      // ch0 held high for 10 cycles: saturating vs wrapping behaviour
      for (int k = 1; k <= 10; k++) begin
         cyc(1'b1, 1'b0, 4'b0001);
         chk("sat_run0",  32'(run_a[2:0]), (k > 7) ? 7 : k);
         chk("wrap_run0", 32'(run_w[2:0]), ((k - 1) % 7) + 1);
         chk("sat_hit",   32'(hit_a), (k == 3) ? 1 : 0);
         chk("wrap_hit",  32'(hit_w), (k == 3 || k == 10) ? 1 : 0);
         chk("sat_end",   32'(end_a), 0);
         chk("wrap_end",  32'(end_w), 0);
      end
      cyc(1'b1, 1'b0, 4'b0000);
      chk("sat_end0",   32'(end_a), 1);
      chk("sat_last0",  32'(last_a), 7);
      chk("sat_run_z",  32'(run_a), 0);
      chk("wrap_end0",  32'(end_w), 1);
      chk("wrap_last0", 32'(last_w), 3);
      chk("done_a_pre", 32'(done_a), 0);
      cyc(1'b1, 1'b0, 4'b0000);
      chk("done_a_1",   32'(done_a), 1);
      chk("done_w_1",   32'(done_w), 1);
      chk("done_c_1",   32'(done_c), 1);
      chk("no_end",     32'(end_a), 0);

      // ch1 with en pattern 1,1,0,0,1
      cyc(1'b1, 1'b0, 4'b0010);
      chk("en_run1_c1", 32'(run_a[5:3]), 1);
      chk("en_hit_c1",  32'(hit_a), 0);
      cyc(1'b1, 1'b0, 4'b0010);
      chk("en_run1_c2", 32'(run_a[5:3]), 2);
      cyc(1'b0, 1'b0, 4'b0010);
      chk("en_run1_c3", 32'(run_a[5:3]), 2);
      chk("en_end_c3",  32'(end_a), 0);
      cyc(1'b0, 1'b0, 4'b0000);
      chk("en_run1_c4", 32'(run_a[5:3]), 2);
      chk("en_end_c4",  32'(end_a), 0);
      chk("en_last_c4", 32'(last_a), 0);
      cyc(1'b1, 1'b0, 4'b0010);
      chk("en_run1_c5", 32'(run_a[5:3]), 3);
      chk("en_hit_c5",  32'(hit_a), 4'b0010);
      cyc(1'b1, 1'b0, 4'b0000);
      chk("en_end1",    32'(end_a), 4'b0010);
      chk("en_last1",   32'(last_a), 12'h018);
      cyc(1'b1, 1'b0, 4'b0000);
      chk("done_a_2",   32'(done_a), 2);
      chk("done_c_2",   32'(done_c), 2);

      // clear zeroes the counters; then three simultaneous ends
      cyc(1'b1, 1'b1, 4'b0000);
      chk("clr_end",    32'(end_a), 0);
      cyc(1'b1, 1'b0, 4'b0111);
      chk("clr_done_a", 32'(done_a), 0);
      chk("clr_done_c", 32'(done_c), 0);
      chk("tri_run",    32'(run_a), 12'h049);
      cyc(1'b1, 1'b0, 4'b0111);
      cyc(1'b1, 1'b0, 4'b0000);
      chk("tri_end",    32'(end_a), 4'b0111);
      chk("tri_last",   32'(last_a), 12'h092);
      cyc(1'b1, 1'b0, 4'b0001);
      chk("tri_done_a", 32'(done_a), 3);
      chk("tri_done_c", 32'(done_c), 3);
      cyc(1'b1, 1'b0, 4'b0000);
      chk("one_end",    32'(end_c), 4'b0001);
      cyc(1'b1, 1'b0, 4'b0000);
      chk("sat_done_a", 32'(done_a), 4);
      chk("sat_done_c", 32'(done_c), 3);

      // clear mid-run on ch2
      for (int k = 1; k <= 4; k++) begin
         cyc(1'b1, 1'b0, 4'b0100);
         chk("mid_run2", 32'(run_a[8:6]), k);
         chk("mid_hit",  32'(hit_a), (k == 3) ? 4'b0100 : 0);
      end
      cyc(1'b1, 1'b1, 4'b0100);
      chk("mclr_run",   32'(run_a), 0);
      chk("mclr_hit",   32'(hit_a), 0);
      chk("mclr_end",   32'(end_a), 0);
      chk("mclr_last",  32'(last_a), 0);
      cyc(1'b1, 1'b0, 4'b0100);
      chk("mclr_run2",  32'(run_a[8:6]), 1);
      chk("mclr_done",  32'(done_a), 0);

      // reset asserted mid-run: immediate zero, no end and no count afterwards
      cyc(1'b1, 1'b0, 4'b0100);
      chk("pre_rst_run2", 32'(run_a[8:6]), 2);
      #1;
      reset_n = 1'b0;
      #1;
      chk("arst_run",   32'(run_a), 0);
      chk("arst_hit",   32'(hit_a), 0);
      @(negedge clk);
      reset_n = 1'b1;
      in_v    = 4'b0000;
      #1;
      chk("arst_end",   32'(end_a), 0);
      chk("arst_last",  32'(last_a), 0);
      cyc(1'b1, 1'b0, 4'b0000);
      chk("arst_done",  32'(done_a), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
